// File: rtl/dpi_video_rx.sv
// -----------------------------------------------------------------------------
// dpi_video_rx
//   Receive side of a parallel RGB565 DPI panel interface. The block recovers
//   the column and line of each active pixel, measures the frame geometry
//   (active width, active height, horizontal total) and declares lock once
//   enough consecutive frames agree. lost_o pulses when that lock is dropped,
//   either by a bad frame or by the VSYNC watchdog.
//
// Ports
//   pxclk_i   pixel clock, all logic on the rising edge
//   rstn_i    asynchronous reset, active-low
//   de_i      data enable (DEN)
//   hsync_i   horizontal sync, active level set by HSYNC_POL
//   vsync_i   vertical sync, active level set by VSYNC_POL
//   r_i/g_i/b_i  RGB565 colour components
//   valid_o   pixel_o/col_o/lin_o carry a pixel this cycle
//   pixel_o   {r,g,b}
//   col_o     column of the pixel
//   lin_o     line of the pixel
//   sof_o     first valid pixel of a frame
//   width_o   active pixels per line of the last closed frame
//   height_o  active lines of the last closed frame
//   htotal_o  cycles between the last two HSYNC active edges
//   locked_o  geometry stable for LOCK_FRAMES frames
//   lost_o    one-cycle pulse when locked_o falls
// -----------------------------------------------------------------------------
module dpi_video_rx #(
  parameter int CW          = 9,
  parameter int LW          = 9,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 262144
) (
  input  logic          pxclk_i,
  input  logic          rstn_i,
  input  logic          de_i,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic [4:0]    r_i,
  input  logic [5:0]    g_i,
  input  logic [4:0]    b_i,
  output logic          valid_o,
  output logic [15:0]   pixel_o,
  output logic [CW-1:0] col_o,
  output logic [LW-1:0] lin_o,
  output logic          sof_o,
  output logic [CW:0]   width_o,
  output logic [LW:0]   height_o,
  output logic [10:0]   htotal_o,
  output logic          locked_o,
  output logic          lost_o
);

  localparam int MW  = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]  COL_MAX  = '1;
  localparam logic [LW-1:0]  LIN_MAX  = '1;
  localparam logic [MW-1:0]  LOCK_MAX = MW'(LOCK_FRAMES);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT);
  localparam logic [10:0]    HT_MAX   = 11'h7FF;

  // Polarity-corrected syncs and their previous-cycle copies.
  logic vs_act, hs_act;
  logic de_q, vs_q, hs_q;

  assign vs_act = (vsync_i == VSYNC_POL);
  assign hs_act = (hsync_i == HSYNC_POL);

  logic vs_edge, hs_edge, de_rise, de_fall;

  assign vs_edge = vs_act & ~vs_q;
  assign hs_edge = hs_act & ~hs_q;
  assign de_rise = de_i & ~de_q;
  assign de_fall = ~de_i & de_q;

  // Frame tracking state.
  logic [CW-1:0]  col_cnt;
  logic [LW-1:0]  lin_cnt;
  logic [CW-1:0]  ref_width;
  logic           frame_bad;
  logic           frame_seen;
  logic           sof_pend;
  logic [MW-1:0]  match_cnt;
  logic [WDW-1:0] wd_cnt;
  logic [10:0]    hcnt;

  // Pixel path decode. A VS edge or DE rise makes this pixel column 0; a VS
  // edge also makes it line 0, so a pixel coincident with the VS edge opens
  // the new frame even when frame_seen is still clear.
  logic          pix_en;
  logic [CW-1:0] col_idx;
  logic [LW-1:0] lin_idx;
  logic          col_sat;
  logic [CW-1:0] col_inc;

  assign pix_en  = de_i & (frame_seen | vs_edge);
  assign col_idx = (vs_edge | de_rise) ? '0 : col_cnt;
  assign lin_idx = vs_edge ? '0 : lin_cnt;
  assign col_sat = (col_idx == COL_MAX);
  assign col_inc = col_sat ? col_idx : col_idx + CW'(1);

  // Line close. The *_eff values already include a line closing this cycle,
  // so a DE fall coincident with the VS edge is counted in the closing frame.
  logic          close_evt;
  logic          lin_sat;
  logic [CW-1:0] ref_eff;
  logic [LW-1:0] lin_eff;
  logic          bad_eff;
  logic          frame_good;

  assign close_evt = de_fall & frame_seen;
  assign lin_sat   = (lin_cnt == LIN_MAX);
  assign ref_eff   = (close_evt && lin_cnt == '0) ? col_cnt : ref_width;
  assign lin_eff   = (close_evt && !lin_sat) ? lin_cnt + LW'(1) : lin_cnt;

  // DE held high straight through the VS edge leaves the last line unclosed,
  // so the closing frame cannot be trusted.
  assign bad_eff = frame_bad
                 | (close_evt && lin_cnt != '0 && col_cnt != ref_width)
                 | (close_evt && lin_sat)
                 | (vs_edge & de_i & de_q);

  assign frame_good = !bad_eff && (lin_eff != '0)
                    && ({1'b0, ref_eff} == width_o)
                    && ({1'b0, lin_eff} == height_o);

  // The watchdog saturates at TIMEOUT, so it fires once per silence.
  logic wd_hit;
  assign wd_hit = !vs_edge && (wd_cnt == WD_LAST);

  logic [MW-1:0] match_nxt;
  logic          locked_nxt;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default on
    // entry; a path that leaves it unassigned would infer a latch.
    match_nxt = match_cnt;
    if (vs_edge) begin
      if (frame_seen) begin
        if (!frame_good)
          match_nxt = '0;
        else if (match_cnt != LOCK_MAX)
          match_nxt = match_cnt + MW'(1);
      end
    end else if (wd_hit) begin
      match_nxt = '0;
    end
  end

  assign locked_nxt = (match_nxt >= LOCK_MAX);

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge pxclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      de_q       <= 1'b0;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      col_cnt    <= '0;
      lin_cnt    <= '0;
      ref_width  <= '0;
      frame_bad  <= 1'b0;
      frame_seen <= 1'b0;
      sof_pend   <= 1'b0;
      match_cnt  <= '0;
      wd_cnt     <= '0;
      hcnt       <= '0;
      valid_o    <= 1'b0;
      pixel_o    <= '0;
      col_o      <= '0;
      lin_o      <= '0;
      sof_o      <= 1'b0;
      width_o    <= '0;
      height_o   <= '0;
      htotal_o   <= '0;
      locked_o   <= 1'b0;
      lost_o     <= 1'b0;
    end else begin
      de_q <= de_i;
      vs_q <= vs_act;
      hs_q <= hs_act;

      // Pixel output; data outputs hold while no pixel is valid.
      valid_o <= pix_en;
      sof_o   <= pix_en & (vs_edge | sof_pend);
      if (pix_en) begin
        pixel_o <= {r_i, g_i, b_i};
        col_o   <= col_idx;
        lin_o   <= lin_idx;
      end

      if (pix_en)
        sof_pend <= 1'b0;
      else if (vs_edge)
        sof_pend <= 1'b1;

      if (pix_en)
        col_cnt <= col_inc;
      else if (vs_edge)
        col_cnt <= '0;

      ref_width <= ref_eff;

      if (vs_edge) begin
        if (frame_seen) begin
          width_o  <= {1'b0, ref_eff};
          height_o <= {1'b0, lin_eff};
        end
        lin_cnt    <= '0;
        frame_bad  <= 1'b0;
        frame_seen <= 1'b1;
      end else begin
        lin_cnt   <= lin_eff;
        frame_bad <= bad_eff | (pix_en & col_sat);
        if (wd_hit)
          frame_seen <= 1'b0;
      end

      match_cnt <= match_nxt;
      locked_o  <= locked_nxt;
      lost_o    <= locked_o & ~locked_nxt;

      if (vs_edge)
        wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)
        wd_cnt <= wd_cnt + WDW'(1);

      // Horizontal total: the counter restarts on each HSYNC active edge,
      // and the edge cycle itself is part of the line just measured.
      if (hs_edge) begin
        hcnt     <= '0;
        htotal_o <= (hcnt == HT_MAX) ? HT_MAX : hcnt + 11'd1;
      end else if (hcnt != HT_MAX) begin
        hcnt <= hcnt + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_dpi_video_rx.sv
// -----------------------------------------------------------------------------
// tb_dpi_video_rx
//   Directed bench for dpi_video_rx on a small panel geometry: 20x6 active,
//   30 cycles per line, 10 lines per frame, both syncs active-low. The
//   watchdog timeout is shortened to 1000 cycles.
// -----------------------------------------------------------------------------
module tb_dpi_video_rx;

  localparam int CW    = 9;
  localparam int LW    = 9;
  localparam int TMO   = 1000;
  localparam int H_TOT = 30;
  localparam int H_ACT = 20;
  localparam int V_TOT = 10;
  localparam int V_ACT = 6;

  logic          pxclk_i = 1'b0;
  logic          rstn_i  = 1'b1;
  logic          de_i    = 1'b0;
  logic          hsync_i = 1'b1;
  logic          vsync_i = 1'b1;
  logic [4:0]    r_i     = '0;
  logic [5:0]    g_i     = '0;
  logic [4:0]    b_i     = '0;
  logic          valid_o;
  logic [15:0]   pixel_o;
  logic [CW-1:0] col_o;
  logic [LW-1:0] lin_o;
  logic          sof_o;
  logic [CW:0]   width_o;
  logic [LW:0]   height_o;
  logic [10:0]   htotal_o;
  logic          locked_o;
  logic          lost_o;

  int errors   = 0;
  int checks   = 0;
  int lost_cnt = 0;

  always #5 pxclk_i = ~pxclk_i;

  dpi_video_rx #(
    .CW(CW), .LW(LW), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .LOCK_FRAMES(2), .TIMEOUT(TMO)
  ) dut (
    .pxclk_i(pxclk_i), .rstn_i(rstn_i), .de_i(de_i), .hsync_i(hsync_i),
    .vsync_i(vsync_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .valid_o(valid_o), .pixel_o(pixel_o), .col_o(col_o), .lin_o(lin_o),
    .sof_o(sof_o), .width_o(width_o), .height_o(height_o),
    .htotal_o(htotal_o), .locked_o(locked_o), .lost_o(lost_o)
  );

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [15:0] d);
    de_i    = de;
    hsync_i = hs;
    vsync_i = vs;
    {r_i, g_i, b_i} = d;
    @(posedge pxclk_i);
    #1;
    if (lost_o) lost_cnt++;
  endtask

  // One full frame starting with the VSYNC active edge. Active area begins at
  // (h_start, v_start); line short_ln carries one pixel fewer. Each pixel is
  // checked against the ramp col + lin*H_ACT with 1-cycle latency.
  task automatic drive_frame(input int h_start, input int v_start,
                             input int short_ln, input string tag);
    int pe, vcnt, scnt, col, lin, len, exp_v;
    logic de;
    logic [15:0] p;
    pe = 0; vcnt = 0; scnt = 0;
    for (int ln = 0; ln < V_TOT; ln++) begin
      for (int h = 0; h < H_TOT; h++) begin
        col = h - h_start;
        lin = ln - v_start;
        len = (lin == short_ln) ? H_ACT - 1 : H_ACT;
        de  = (lin >= 0) && (lin < V_ACT) && (col >= 0) && (col < len);
        p   = 16'(col + lin * H_ACT);
        step(de, h >= 3, ln >= 2, de ? p : 16'hA5C3);
        if (valid_o) vcnt++;
        if (sof_o) scnt++;
        if (de) begin
          if (valid_o !== 1'b1 || col_o !== CW'(col) || lin_o !== LW'(lin) ||
              pixel_o !== p || sof_o !== ((col == 0) && (lin == 0)))
            pe++;
        end else if (valid_o !== 1'b0 || sof_o !== 1'b0) begin
          pe++;
        end
      end
    end
    exp_v = V_ACT * H_ACT - ((short_ln >= 0) ? 1 : 0);
    checks++;
    if (pe !== 0) begin
      errors++;
      $display("FAIL %s pixel_stream: mismatching cycles=%0d, want 0", tag, pe);
    end
    checks++;
    if (vcnt !== exp_v) begin
      errors++;
      $display("FAIL %s valid_count: got %0d, want %0d", tag, vcnt, exp_v);
    end
    checks++;
    if (scnt !== 1) begin
      errors++;
      $display("FAIL %s sof_count: got %0d, want 1", tag, scnt);
    end
  endtask

  task automatic test_reset();
    logic [68:0] all_out;
    int vcnt;
    rstn_i = 1'b1;
    #2 rstn_i = 1'b0;
    #21;
    all_out = {valid_o, sof_o, locked_o, lost_o, pixel_o, col_o, lin_o,
               width_o, height_o, htotal_o};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", all_out);
    end
    rstn_i = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h0);
    // DE activity before any VS edge must be ignored.
    vcnt = 0;
    for (int h = 0; h < 2 * H_TOT; h++) begin
      step((h % H_TOT) >= 5 && (h % H_TOT) < 25, (h % H_TOT) >= 3, 1'b1, 16'h5555);
      if (valid_o) vcnt++;
    end
    checks++;
    if (vcnt !== 0) begin
      errors++;
      $display("FAIL pre_vs_valid: got %0d valid cycles, want 0", vcnt);
    end
  endtask

  task automatic test_geometry();
    drive_frame(5, 3, -1, "A1");
    drive_frame(5, 3, -1, "A2");
    checks++;
    if (width_o !== 10'd20) begin
      errors++; $display("FAIL A2 width: got %0d, want 20", width_o);
    end
    checks++;
    if (height_o !== 10'd6) begin
      errors++; $display("FAIL A2 height: got %0d, want 6", height_o);
    end
    checks++;
    if (htotal_o !== 11'd30) begin
      errors++; $display("FAIL A2 htotal: got %0d, want 30", htotal_o);
    end
    checks++;
    if (locked_o !== 1'b0) begin
      errors++; $display("FAIL A2 locked: got %b, want 0", locked_o);
    end
    drive_frame(5, 3, -1, "A3");
    checks++;
    if (locked_o !== 1'b0) begin
      errors++; $display("FAIL A3 locked: got %b, want 0", locked_o);
    end
    drive_frame(5, 3, -1, "A4");
    checks++;
    if (locked_o !== 1'b1) begin
      errors++; $display("FAIL A4 locked: got %b, want 1", locked_o);
    end
  endtask

  task automatic test_short_line();
    int l0;
    l0 = lost_cnt;
    drive_frame(5, 3, 2, "B1");
    checks++;
    if (locked_o !== 1'b1) begin
      errors++; $display("FAIL B1 locked: got %b, want 1", locked_o);
    end
    drive_frame(5, 3, -1, "B2");
    checks++;
    if (locked_o !== 1'b0) begin
      errors++; $display("FAIL B2 locked: got %b, want 0", locked_o);
    end
    checks++;
    if (lost_cnt - l0 !== 1) begin
      errors++; $display("FAIL B2 lost_pulses: got %0d, want 1", lost_cnt - l0);
    end
    checks++;
    if (width_o !== 10'd20 || height_o !== 10'd6) begin
      errors++;
      $display("FAIL B2 geometry: got %0dx%0d, want 20x6", width_o, height_o);
    end
    drive_frame(5, 3, -1, "B3");
    checks++;
    if (locked_o !== 1'b0) begin
      errors++; $display("FAIL B3 locked: got %b, want 0", locked_o);
    end
    drive_frame(5, 3, -1, "B4");
    checks++;
    if (locked_o !== 1'b1) begin
      errors++; $display("FAIL B4 relock: got %b, want 1", locked_o);
    end
  endtask

  task automatic test_coincident();
    int l0;
    // C1 ends with DE high; C2 starts with DE high: DE straight through VS.
    drive_frame(10, 4, -1, "C1");
    l0 = lost_cnt;
    drive_frame(0, 0, -1, "C2");
    checks++;
    if (height_o !== 10'd5 || width_o !== 10'd20) begin
      errors++;
      $display("FAIL C2 geometry: got %0dx%0d, want 20x5", width_o, height_o);
    end
    checks++;
    if (locked_o !== 1'b0) begin
      errors++; $display("FAIL C2 locked: got %b, want 0", locked_o);
    end
    checks++;
    if (lost_cnt - l0 !== 1) begin
      errors++; $display("FAIL C2 lost_pulses: got %0d, want 1", lost_cnt - l0);
    end
    // C3 ends with DE high; C4 starts with DE low: DE fall coincides with VS.
    drive_frame(10, 4, -1, "C3");
    drive_frame(5, 3, -1, "C4");
    checks++;
    if (height_o !== 10'd6) begin
      errors++; $display("FAIL C4 coincident_fall_height: got %0d, want 6", height_o);
    end
    drive_frame(5, 3, -1, "C5");
    checks++;
    if (locked_o !== 1'b1) begin
      errors++; $display("FAIL C5 locked: got %b, want 1", locked_o);
    end
  endtask

  task automatic test_timeout();
    int l0, early, late, h;
    l0 = lost_cnt; early = 0; late = 0;
    for (int n = 0; n < TMO + 200; n++) begin
      h = n % H_TOT;
      step(h >= 5 && h < 25, h >= 3, 1'b1, 16'h1234);
      if (n < 200 && valid_o) early++;
      if (n >= TMO && valid_o) late++;
    end
    checks++;
    if (early !== 135) begin
      errors++; $display("FAIL wd_early_valid: got %0d, want 135", early);
    end
    checks++;
    if (late !== 0) begin
      errors++; $display("FAIL wd_late_valid: got %0d, want 0", late);
    end
    checks++;
    if (locked_o !== 1'b0) begin
      errors++; $display("FAIL wd_locked: got %b, want 0", locked_o);
    end
    checks++;
    if (lost_cnt - l0 !== 1) begin
      errors++; $display("FAIL wd_lost_pulses: got %0d, want 1", lost_cnt - l0);
    end
    checks++;
    if (width_o !== 10'd20 || height_o !== 10'd6 || htotal_o !== 11'd30) begin
      errors++;
      $display("FAIL wd_hold: got %0dx%0d ht %0d, want 20x6 ht 30",
               width_o, height_o, htotal_o);
    end
    drive_frame(5, 3, -1, "D1");
    drive_frame(5, 3, -1, "D2");
    checks++;
    if (locked_o !== 1'b0) begin
      errors++; $display("FAIL D2 locked: got %b, want 0", locked_o);
    end
    drive_frame(5, 3, -1, "D3");
    checks++;
    if (locked_o !== 1'b1) begin
      errors++; $display("FAIL D3 relock: got %b, want 1", locked_o);
    end
  endtask

  task automatic test_async_reset();
    logic [68:0] all_out;
    int vcnt;
    for (int h = 0; h < 10; h++) step(h >= 5, h >= 3, 1'b1, 16'h7777);
    #3 rstn_i = 1'b0;
    #1;
    all_out = {valid_o, sof_o, locked_o, lost_o, pixel_o, col_o, lin_o,
               width_o, height_o, htotal_o};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, want 0", all_out);
    end
    step(1'b1, 1'b1, 1'b1, 16'h7777);
    step(1'b1, 1'b1, 1'b1, 16'h7777);
    rstn_i = 1'b1;
    vcnt = 0;
    for (int h = 0; h < 2 * H_TOT; h++) begin
      step((h % H_TOT) >= 5 && (h % H_TOT) < 25, (h % H_TOT) >= 3, 1'b1, 16'h3C3C);
      if (valid_o) vcnt++;
    end
    checks++;
    if (vcnt !== 0) begin
      errors++; $display("FAIL post_reset_valid: got %0d, want 0", vcnt);
    end
    drive_frame(5, 3, -1, "E1");
    drive_frame(5, 3, -1, "E2");
    checks++;
    if (width_o !== 10'd20 || height_o !== 10'd6 || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL E2 geometry: got %0dx%0d locked %b, want 20x6 locked 0",
               width_o, height_o, locked_o);
    end
  endtask

  initial begin
    test_reset();
    test_geometry();
    test_short_line();
    test_coincident();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
